// File: rtl/seg7_pkg.sv
// Active-low 7-segment patterns (bit6=a ... bit0=g) shared by the scan decoder.
// Pure constants; no timing or flow control.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_lookup.sv
// Segment pattern -> {is_hex, is_blank, nibble}; combinational, zero latency,
// no backpressure.
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       is_hex,
    output logic       is_blank,
    output logic [3:0] nibble
);
    always_comb begin
        is_hex   = 1'b1;
        is_blank = 1'b0;
        nibble   = 4'h0;
        case (seg_n)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_hex = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed active-low 7-seg bus back into a hex frame with err/blank flags.
// Frame outputs update 1 cycle after the completing capture; passive monitor, no backpressure.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [N_DIGITS-1:0]   an_n,
    output logic [4*N_DIGITS-1:0] value,
    output logic                  frame_valid,
    output logic [N_DIGITS-1:0]   digit_err,
    output logic [N_DIGITS-1:0]   blank,
    output logic                  stale
);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VW = 4 * N_DIGITS;

    logic [N_DIGITS-1:0] an_q, an_p;
    logic [6:0]          seg_q, seg_p;
    logic [SW-1:0]       stab_cnt;
    logic [WW-1:0]       wd_cnt;
    logic [N_DIGITS-1:0] seen, seen_nxt, dig_mask;
    logic [VW-1:0]       sh_val, sh_val_n;
    logic [N_DIGITS-1:0] sh_err, sh_err_n, sh_blank, sh_blank_n;
    logic [IW-1:0]       dig_idx;
    int                  n_low;
    logic                one_cold, stable, cap, done, wd_hit;
    logic                lk_hex, lk_blank;
    logic [3:0]          lk_nib;

    seg7_lookup u_lookup (
        .seg_n    (seg_q),
        .is_hex   (lk_hex),
        .is_blank (lk_blank),
        .nibble   (lk_nib)
    );

    // One-cold detect doubles as the digit encoder: the last low bit wins,
    // which only matters when exactly one bit is low.
    always_comb begin
        n_low   = 0;
        dig_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) begin
                n_low   = n_low + 1;
                dig_idx = IW'(i);
            end
        end
    end

    assign one_cold = (n_low == 1);
    assign stable   = one_cold && (an_q == an_p) && (seg_q == seg_p);
    assign cap      = stable && (stab_cnt == SW'(STABLE_CYC - 2));
    assign dig_mask = N_DIGITS'(1) << dig_idx;
    assign seen_nxt = seen | dig_mask;
    assign done     = cap && (&seen_nxt);
    assign wd_hit   = !cap && (wd_cnt == WW'(TIMEOUT_CYC - 1));

    always_comb begin
        sh_val_n   = sh_val;
        sh_err_n   = sh_err;
        sh_blank_n = sh_blank;
        if (lk_hex) sh_val_n[4*dig_idx +: 4] = lk_nib;
        sh_err_n[dig_idx]   = !lk_hex && !lk_blank;
        sh_blank_n[dig_idx] = lk_blank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q     <= '0;
            seg_q    <= '0;
            an_p     <= '0;
            seg_p    <= '0;
            stab_cnt <= '0;
            wd_cnt   <= '0;
            seen     <= '0;
            sh_val   <= '0;
            sh_err   <= '0;
            sh_blank <= '0;
        end else begin
            an_q  <= an_n;
            seg_q <= seg_n;
            an_p  <= an_q;
            seg_p <= seg_q;

            if (!stable) stab_cnt <= '0;
            else if (stab_cnt != SW'(STABLE_CYC - 1)) stab_cnt <= stab_cnt + 1'b1;

            // Count starts at 1 so the value equals cycles elapsed since capture.
            if (cap) wd_cnt <= WW'(1);
            else if (wd_cnt != WW'(TIMEOUT_CYC)) wd_cnt <= wd_cnt + 1'b1;

            if (cap) begin
                sh_val   <= sh_val_n;
                sh_err   <= sh_err_n;
                sh_blank <= sh_blank_n;
                seen     <= done ? '0 : seen_nxt;
            end else if (wd_hit) begin
                seen <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            frame_valid <= 1'b0;
            digit_err   <= '0;
            blank       <= '1;
            stale       <= 1'b0;
        end else begin
            frame_valid <= done;
            if (done) begin
                value     <= sh_val_n;
                digit_err <= sh_err_n;
                blank     <= sh_blank_n;
                stale     <= 1'b0;
            end else if (wd_hit) begin
                stale <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized scoreboard bench for seg7_scan_decoder against a dwell-level reference model.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  e;
        logic [3:0]  b;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_n = 7'h7f;
    logic [ND-1:0] an_n = '1;
    logic [15:0]   value;
    logic          frame_valid;
    logic [ND-1:0] digit_err, blank;
    logic          stale;

    seg7_scan_decoder #(.N_DIGITS(ND), .STABLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n), .value(value),
        .frame_valid(frame_valid), .digit_err(digit_err), .blank(blank), .stale(stale)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_fv_cyc = 0;
    frame_t sb[$];

    logic [15:0] m_val;
    logic [3:0]  m_err, m_blank, m_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // 0..15 hex code, 16 blank, 17 anything else
    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (hex_pat[i] == p) return i;
        return (p == 7'b1111111) ? 16 : 17;
    endfunction

    task automatic model_reset();
        m_val = '0; m_err = '0; m_blank = '0; m_seen = '0;
    endtask

    task automatic model_capture(input int d, input logic [6:0] p);
        int code;
        frame_t f;
        code = decode(p);
        if (code < 16) begin
            m_val[d*4 +: 4] = 4'(code);
            m_err[d] = 1'b0; m_blank[d] = 1'b0;
        end else if (code == 16) begin
            m_err[d] = 1'b0; m_blank[d] = 1'b1;
        end else begin
            m_err[d] = 1'b1; m_blank[d] = 1'b0;
        end
        m_seen[d] = 1'b1;
        if (m_seen == 4'hf) begin
            f.v = m_val; f.e = m_err; f.b = m_blank;
            sb.push_back(f);
            m_seen = '0;
        end
    endtask

    // One dwell: digit d shows pattern p for n clock samples.
    task automatic show(input int d, input logic [6:0] p, input int n);
        an_n  = ~(4'b0001 << d);
        seg_n = p;
        if (n >= SC) model_capture(d, p);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input logic [3:0] a, input logic [6:0] p, input int n);
        an_n = a; seg_n = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_value"}, 32'(value), 32'h0);
        chk({tag, "_fv"}, 32'(frame_valid), 32'h0);
        chk({tag, "_err"}, 32'(digit_err), 32'h0);
        chk({tag, "_blank"}, 32'(blank), 32'hf);
        chk({tag, "_stale"}, 32'(stale), 32'h0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(sb.size()), 32'h0);
    endtask

    // Monitor: every frame_valid pops the oldest expected frame.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst_n && frame_valid) begin
                last_fv_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame value=%h err=%b blank=%b at cycle %0d",
                             value, digit_err, blank, cyc);
                end else begin
                    f = sb.pop_front();
                    chk("frame_value", 32'(value), 32'(f.v));
                    chk("frame_err", 32'(digit_err), 32'(f.e));
                    chk("frame_blank", 32'(blank), 32'(f.b));
                    chk("frame_stale_clr", 32'(stale), 32'h0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int pd, d, n, got, r;
        logic [6:0] pp, p;
        logic prev_short;
        model_reset();
        #12;
        check_reset_vals("rst0");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame 0x1234
        show(3, hex_pat[1], 8); show(2, hex_pat[2], 8);
        show(1, hex_pat[3], 8); show(0, hex_pat[4], 8);
        // Error pattern on digit 2 keeps its old nibble
        show(3, hex_pat[5], 6); show(2, 7'b1111110, 6);
        show(1, hex_pat[6], 6); show(0, hex_pat[7], 6);
        // Blank on digit 3
        show(3, 7'b1111111, 5); show(2, hex_pat[9], 5);
        show(1, hex_pat[10], 5); show(0, hex_pat[11], 5);
        // Short dwells on digit 0 must not capture
        show(3, hex_pat[12], 5); show(2, hex_pat[13], 5); show(1, hex_pat[14], 5);
        show(0, hex_pat[15], 3); show(0, hex_pat[0], 3); show(0, hex_pat[8], 3);
        show(0, hex_pat[3], 4);
        // Multi-low and all-off anodes must not capture
        show(3, hex_pat[2], 4); show(2, hex_pat[4], 4); show(1, hex_pat[6], 4);
        drive_raw(4'b1100, hex_pat[9], 20);
        drive_raw(4'b1111, hex_pat[9], 6);
        show(0, hex_pat[1], 4);
        drain("drain_directed");

        // Randomized dwells
        pd = -1; pp = '0; prev_short = 1'b1;
        for (int k = 0; k < 80; k++) begin
            d = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r == 0) p = 7'b1111111;
            else if (r == 1) p = 7'($urandom);
            else p = hex_pat[$urandom_range(0, 15)];
            if (d == pd && p == pp) d = (d + 1) % 4;
            if (!prev_short && $urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, SC - 1); prev_short = 1'b1;
            end else begin
                n = $urandom_range(SC, 9); prev_short = 1'b0;
            end
            show(d, p, n);
            pd = d; pp = p;
        end
        drain("drain_random");

        // Idle long enough to time out: partial frame must be dropped
        drive_raw(4'b1111, 7'b1111111, TO + 16);
        @(negedge clk);
        chk("stale_idle", 32'(stale), 32'h1);
        m_seen = '0;
        @(posedge clk); #1;
        show(3, hex_pat[7], 5); show(2, hex_pat[0], 5);
        show(1, hex_pat[10], 5); show(0, hex_pat[5], 5);
        drain("drain_after_stale");

        // Stale rises TO cycles after the capture, i.e. TO-1 after frame_valid
        an_n = '1;
        got = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stale) begin
                got = cyc - last_fv_cyc;
                break;
            end
        end
        chk("stale_delay", 32'(got), 32'(TO - 1));
        m_seen = '0;
        @(posedge clk); #1;
        show(3, hex_pat[13], 4); show(2, hex_pat[12], 4);
        show(1, hex_pat[11], 4); show(0, hex_pat[10], 4);
        drain("drain_stale_clear");

        // Reset mid-frame
        show(3, hex_pat[6], 5);
        an_n = 4'b1011; seg_n = hex_pat[9];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        show(2, hex_pat[2], 5); show(1, hex_pat[4], 5);
        show(0, hex_pat[6], 5); show(3, hex_pat[8], 5);
        drain("drain_post_reset");

        repeat (10) @(negedge clk);
        chk("sb_empty_end", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
